// File: rtl/pkg_uart.sv
// Shared definitions for the UART peripheral: FSM state encodings,
// register offsets inside the UART window and CTRL bit positions.
package pkg_uart;

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_START = 2'd1,
    TX_DATA  = 2'd2,
    TX_STOP  = 2'd3
  } tx_state_t;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_t;

  // Register offsets relative to the UART base (0x2020)
  localparam logic [31:0] OFFS_CTRL = 32'h0;
  localparam logic [31:0] OFFS_DATA = 32'h4;

  // Only this address bit distinguishes CTRL from DATA
  localparam int ADDR_SEL_BIT = 2;

  // CTRL bit positions
  localparam int CTRL_SEND_BIT   = 0;
  localparam int CTRL_NEW_RX_BIT = 1;

endpackage

// File: rtl/module_uart_rx.sv
// UART receiver: two-flop synchronizer, mid-bit sampling FSM and shift
// register. byte_vld is a one-cycle strobe on the edge the stop bit is
// sampled high; byte_data is valid while byte_vld is high.
module module_uart_rx
  import pkg_uart::*;
#(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] byte_data,
  output logic       byte_vld
);

  localparam logic [15:0] LAST = 16'(CLKS_PER_BIT - 1);
  localparam logic [15:0] HALF = 16'(CLKS_PER_BIT / 2 - 1);

  logic       rx_p0;
  logic       rx_p1;
  rx_state_t  state;
  logic [15:0] cnt;
  logic [2:0] idx;
  logic [7:0] shreg;

  // Two-flop synchronizer for the asynchronous line; resets to idle level
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_p0 <= 1'b1;
      rx_p1 <= 1'b1;
    end else begin
      rx_p0 <= rx;
      rx_p1 <= rx_p0;
    end
  end

  // Receive FSM: half-bit start qualification, then one sample per bit period
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RX_IDLE;
      cnt   <= 16'd0;
      idx   <= 3'd0;
      shreg <= 8'd0;
    end else begin
      case (state)
        RX_IDLE: begin
          cnt <= 16'd0;
          idx <= 3'd0;
          if (!rx_p1) state <= RX_START;
        end
        RX_START: begin
          if (cnt == HALF) begin
            cnt   <= 16'd0;
            // A high level at mid start bit is a glitch: drop it silently
            state <= rx_p1 ? RX_IDLE : RX_DATA;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        RX_DATA: begin
          if (cnt == LAST) begin
            cnt   <= 16'd0;
            shreg <= {rx_p1, shreg[7:1]};
            if (idx == 3'd7) state <= RX_STOP;
            else             idx   <= idx + 3'd1;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        RX_STOP: begin
          if (cnt == LAST) begin
            cnt   <= 16'd0;
            state <= RX_IDLE;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        default: state <= RX_IDLE;
      endcase
    end
  end

  // A low stop sample is a framing error: no strobe, byte discarded
  assign byte_vld  = (state == RX_STOP) && (cnt == LAST) && rx_p1;
  assign byte_data = shreg;

endmodule

// File: rtl/module_uart_periferico.sv
// Memory-mapped UART peripheral: CTRL/DATA register file, transmit FSM
// and an instance of the receiver. Reads are combinational on addr_i[2].
module module_uart_periferico
  import pkg_uart::*;
#(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        we_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] di_i,
  output logic [31:0] do_o,
  input  logic        rx_i,
  output logic        tx_o
);

  localparam logic [15:0] LAST = 16'(CLKS_PER_BIT - 1);

  logic        send;
  logic        new_rx;
  logic [7:0]  tx_data;
  logic [7:0]  rx_data;
  tx_state_t   tx_state;
  logic [15:0] tx_cnt;
  logic [2:0]  tx_idx;
  logic [7:0]  tx_shreg;
  logic        sel_data;
  logic        wr_ctrl;
  logic        wr_data;
  logic [7:0]  rx_byte;
  logic        rx_vld;
  logic        unused_bus;

  assign sel_data = (addr_i[ADDR_SEL_BIT] == OFFS_DATA[ADDR_SEL_BIT]);
  assign wr_ctrl  = we_i && !sel_data;
  assign wr_data  = we_i && sel_data;

  // Address and data bits outside the decoded fields are don't-care
  assign unused_bus = ^{addr_i[31:3], addr_i[1:0], di_i[31:8]};

  module_uart_rx #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_rx (
    .clk      (clk_i),
    .rst      (rst_i),
    .rx       (rx_i),
    .byte_data(rx_byte),
    .byte_vld (rx_vld)
  );

  // Register file: TX holding register, received byte and new_rx flag
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      tx_data <= 8'd0;
      rx_data <= 8'd0;
      new_rx  <= 1'b0;
    end else begin
      if (wr_data) tx_data <= di_i[7:0];
      if (rx_vld)  rx_data <= rx_byte;
      // Hardware set takes priority over a software clear on the same edge
      if (rx_vld)
        new_rx <= 1'b1;
      else if (wr_ctrl && !di_i[CTRL_NEW_RX_BIT])
        new_rx <= 1'b0;
    end
  end

  // Transmit FSM with registered tx_o; owns the send flag
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      tx_state <= TX_IDLE;
      send     <= 1'b0;
      tx_o     <= 1'b1;
      tx_cnt   <= 16'd0;
      tx_idx   <= 3'd0;
      tx_shreg <= 8'd0;
    end else begin
      case (tx_state)
        TX_IDLE: begin
          tx_o   <= 1'b1;
          tx_cnt <= 16'd0;
          tx_idx <= 3'd0;
          if (wr_ctrl && di_i[CTRL_SEND_BIT]) send <= 1'b1;
          if (send) begin
            tx_state <= TX_START;
            tx_shreg <= tx_data;
            tx_o     <= 1'b0;
          end
        end
        TX_START: begin
          if (tx_cnt == LAST) begin
            tx_cnt   <= 16'd0;
            tx_state <= TX_DATA;
            tx_o     <= tx_shreg[0];
          end else begin
            tx_cnt <= tx_cnt + 16'd1;
          end
        end
        TX_DATA: begin
          if (tx_cnt == LAST) begin
            tx_cnt <= 16'd0;
            if (tx_idx == 3'd7) begin
              tx_state <= TX_STOP;
              tx_o     <= 1'b1;
            end else begin
              tx_idx   <= tx_idx + 3'd1;
              tx_shreg <= {1'b0, tx_shreg[7:1]};
              tx_o     <= tx_shreg[1];
            end
          end else begin
            tx_cnt <= tx_cnt + 16'd1;
          end
        end
        TX_STOP: begin
          if (tx_cnt == LAST) begin
            tx_cnt   <= 16'd0;
            tx_state <= TX_IDLE;
            send     <= 1'b0;
          end else begin
            tx_cnt <= tx_cnt + 16'd1;
          end
        end
        default: tx_state <= TX_IDLE;
      endcase
    end
  end

  // Zero-latency read mux
  always_comb begin
    do_o = 32'd0;
    if (sel_data) do_o = {24'd0, rx_data};
    else          do_o = {30'd0, new_rx, send};
  end

endmodule

// File: tb/tb_module_uart_periferico.sv
// Bench for module_uart_periferico at 16 clocks per bit. Random bytes are
// sent and received; expected line levels and register contents come from
// a frame-level model (bit list per byte, last-good-byte / flag state).
module tb_module_uart_periferico;
  import pkg_uart::*;

  localparam int CPB = 16;
  localparam logic [31:0] CTRL_A = 32'h2020 + OFFS_CTRL;
  localparam logic [31:0] DATA_A = 32'h2020 + OFFS_DATA;

  logic        clk;
  logic        rst_i;
  logic        we_i;
  logic [31:0] addr_i;
  logic [31:0] di_i;
  logic [31:0] do_o;
  logic        rx_i;
  logic        tx_o;

  int n_cmp = 0;
  int n_bad = 0;

  // Frame-level receive model
  logic [7:0] m_rx_data;
  logic       m_new_rx;

  module_uart_periferico #(.CLKS_PER_BIT(CPB)) dut (
    .clk_i (clk),
    .rst_i (rst_i),
    .we_i  (we_i),
    .addr_i(addr_i),
    .di_i  (di_i),
    .do_o  (do_o),
    .rx_i  (rx_i),
    .tx_o  (tx_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    we_i = 1'b1; addr_i = a; di_i = d;
    tick();
    we_i = 1'b0;
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
    addr_i = a;
    #1;
    d = do_o;
  endtask

  // Expected line level of bit slot k (0 = start, 1..8 = data LSB first, 9 = stop)
  function automatic logic frame_bit(input logic [7:0] b, input int k);
    if (k == 0) return 1'b0;
    if (k == 9) return 1'b1;
    return 1'(({24'd0, b} >> (k - 1)) & 32'd1);
  endfunction

  // Send one byte and check every bit slot at its centre; optionally disturb
  // the frame with a busy send request and a DATA write.
  task automatic tx_frame(input logic [7:0] b, input bit inject);
    logic [31:0] rd;
    bus_write(DATA_A, {24'hABCDEF, b});
    bus_write(CTRL_A, 32'h1);
    chk("tx_idle_before_start", {31'd0, tx_o}, 32'd1);
    tick();
    for (int t = 0; t < 10 * CPB; t++) begin
      if (t == 0) chk("tx_start_latency", {31'd0, tx_o}, 32'd0);
      if (t % CPB == CPB / 2) chk($sformatf("tx_bit%0d", t / CPB), {31'd0, tx_o}, {31'd0, frame_bit(b, t / CPB)});
      if (t == 10 * CPB - 1) begin
        bus_read(CTRL_A, rd);
        chk("tx_send_busy_last", rd & 32'h1, 32'h1);
      end
      if (inject && t == 40) begin we_i = 1'b1; addr_i = CTRL_A; di_i = 32'h1; end
      if (inject && t == 60) begin we_i = 1'b1; addr_i = DATA_A; di_i = 32'hFF; end
      tick();
      we_i = 1'b0;
    end
    bus_read(CTRL_A, rd);
    chk("tx_send_clear_at_160", rd & 32'h1, 32'h0);
  endtask

  // Drive one serial frame on rx_i; optionally write CTRL=0 at cycle clr_at;
  // report the cycle after whose edge new_rx first rose (-1 if never).
  task automatic rx_frame(input logic [7:0] b, input bit stop, input int clr_at, output int rise_at);
    logic prev;
    logic cur;
    rise_at = -1;
    addr_i = CTRL_A;
    #1;
    prev = do_o[CTRL_NEW_RX_BIT];
    for (int c = 0; c < 10 * CPB; c++) begin
      if (c % CPB == 0) begin
        if (c == 0)                rx_i = 1'b0;
        else if (c == 9 * CPB)     rx_i = stop;
        else                       rx_i = b[c / CPB - 1];
      end
      if (c == clr_at) begin we_i = 1'b1; addr_i = CTRL_A; di_i = 32'h0; end
      tick();
      we_i = 1'b0;
      addr_i = CTRL_A;
      #1;
      cur = do_o[CTRL_NEW_RX_BIT];
      if (rise_at < 0 && cur && !prev) rise_at = c;
      prev = cur;
    end
    rx_i = 1'b1;
    if (stop) begin
      m_rx_data = b;
      m_new_rx  = 1'b1;
    end
    repeat (24) tick();
  endtask

  task automatic check_regs(input string tag);
    logic [31:0] rd;
    bus_read(CTRL_A, rd);
    chk({tag, "_ctrl_new_rx"}, rd, {30'd0, m_new_rx, 1'b0});
    bus_read(DATA_A, rd);
    chk({tag, "_data"}, rd, {24'd0, m_rx_data});
  endtask

  initial begin
    logic [31:0] rd;
    logic [7:0]  b;
    bit          stop;
    int          rise;
    int          set_cycle;

    rst_i = 1'b1; we_i = 1'b0; addr_i = CTRL_A; di_i = 32'd0; rx_i = 1'b1;
    m_rx_data = 8'd0; m_new_rx = 1'b0;
    tick(); tick();
    rst_i = 1'b0;

    // Reset state
    chk("reset_tx_o", {31'd0, tx_o}, 32'd1);
    bus_read(CTRL_A, rd); chk("reset_ctrl", rd, 32'd0);
    bus_read(DATA_A, rd); chk("reset_data", rd, 32'd0);

    // Transmit: fixed pattern then random bytes
    tx_frame(8'hA5, 1'b0);
    for (int i = 0; i < 3; i++) tx_frame(8'($urandom_range(0, 255)), 1'b0);

    // Receive 0x3C; keep the edge at which new_rx rose
    rx_frame(8'h3C, 1'b1, -1, rise);
    set_cycle = rise;
    chk("rx_set_seen", {31'd0, rise >= 0}, 32'd1);
    check_regs("rx_3c");
    bus_write(CTRL_A, 32'h2);
    check_regs("rx_clear_ignored");
    bus_write(CTRL_A, 32'h0);
    m_new_rx = 1'b0;
    check_regs("rx_cleared");

    // Short low glitch must be rejected
    rx_i = 1'b0;
    repeat (4) tick();
    rx_i = 1'b1;
    repeat (40) tick();
    check_regs("rx_glitch");

    // Framing error: byte dropped
    rx_frame(8'h55, 1'b0, -1, rise);
    check_regs("rx_framing");

    // Random frames, some with bad stop bits, clearing in between
    for (int i = 0; i < 4; i++) begin
      b = 8'($urandom_range(0, 255));
      stop = ($urandom_range(0, 3) != 0);
      rx_frame(b, stop, -1, rise);
      check_regs($sformatf("rx_rand%0d", i));
      bus_write(CTRL_A, 32'h0);
      m_new_rx = 1'b0;
    end

    // Overrun: second byte overwrites, flag stays set
    rx_frame(8'h11, 1'b1, -1, rise);
    rx_frame(8'h22, 1'b1, -1, rise);
    check_regs("rx_overrun");

    // Software clear on the exact set edge loses to the set
    bus_write(CTRL_A, 32'h0);
    m_new_rx = 1'b0;
    rx_frame(8'($urandom_range(0, 255)), 1'b1, set_cycle, rise);
    check_regs("rx_set_wins");
    bus_write(CTRL_A, 32'h0);
    m_new_rx = 1'b0;

    // Busy send request and mid-frame DATA write leave the frame intact
    b = 8'($urandom_range(0, 254));
    tx_frame(b, 1'b1);
    for (int i = 0; i < 12; i++) begin
      repeat (16) tick();
      chk("tx_single_frame_idle", {31'd0, tx_o}, 32'd1);
    end

    // Reset mid-frame aborts transmission immediately
    bus_write(DATA_A, 32'h00);
    bus_write(CTRL_A, 32'h1);
    repeat (50) tick();
    chk("tx_mid_frame_low", {31'd0, tx_o}, 32'd0);
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    m_rx_data = 8'd0; m_new_rx = 1'b0;
    chk("reset_mid_tx_o", {31'd0, tx_o}, 32'd1);
    check_regs("reset_mid");
    for (int i = 0; i < 12; i++) begin
      repeat (16) tick();
      chk("tx_after_abort_idle", {31'd0, tx_o}, 32'd1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
